// File: rtl/nios_system_nios2_gen2_0_cpu_oci_dtrace_ctrl.sv
// Data-trace capture controller: writes compressed trace frames into a
// circular trace RAM with arm/trigger/post-trigger sequencing, then serves
// oldest-first readout to the debug host through a req/ack port.
module nios_system_nios2_gen2_0_cpu_oci_dtrace_ctrl #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned POST_TRIG = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trig,
  input  logic              test_ending,
  input  logic              dct_valid,
  input  logic [29:0]       dct_buffer,
  input  logic [3:0]        dct_count,
  output logic              tm_we,
  output logic [ADDR_W-1:0] tm_waddr,
  output logic [33:0]       tm_wdata,
  output logic [ADDR_W-1:0] tm_raddr,
  input  logic [33:0]       tm_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [33:0]       rd_data,
  output logic [1:0]        state,
  output logic              wrapped,
  output logic [ADDR_W:0]   num_entries,
  output logic              trace_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_TRIG  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH       = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] WPTR_MAX    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   POST_TRIG_V = (ADDR_W+1)'(POST_TRIG);
  localparam bit                POST_ZERO   = (POST_TRIG == 0);

  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [ADDR_W-1:0] post_cnt, post_cnt_n;
  logic [ADDR_W-1:0] rd_idx, rd_idx_n;
  logic              rd_s1, rd_s1_n;
  logic              rd_s2, rd_s2_n;
  logic [1:0]        state_n;
  logic              wrapped_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [33:0]       wdata_n;
  logic [ADDR_W-1:0] raddr_n;
  logic              ack_n;
  logic [33:0]       rdata_n;
  logic [ADDR_W:0]   num_entries_n;
  logic              accept;
  logic [ADDR_W-1:0] start;

  // Next-state, capture pointer and read-pipeline logic.
  always_comb begin
    state_n    = state;
    wptr_n     = wptr;
    wrapped_n  = wrapped;
    post_cnt_n = post_cnt;
    we_n       = 1'b0;
    waddr_n    = tm_waddr;
    wdata_n    = tm_wdata;
    rd_s1_n    = 1'b0;
    rd_s2_n    = rd_s1;
    rd_idx_n   = rd_idx;
    raddr_n    = tm_raddr;
    ack_n      = rd_s2;
    rdata_n    = rd_s2 ? tm_rdata : rd_data;
    start      = wrapped ? wptr : '0;
    accept     = dct_valid && (dct_count != 4'd0) &&
                 ((state == S_ARMED) || (state == S_TRIG));

    if (accept) begin
      we_n    = 1'b1;
      waddr_n = wptr;
      wdata_n = {dct_count, dct_buffer};
      wptr_n  = wptr + 1'b1;
      if (wptr == WPTR_MAX) wrapped_n = 1'b1;
    end

    // Stage 2 of a read: physical address rotated by the oldest entry.
    if (rd_s1) raddr_n = start + rd_idx;

    // Stage 1: accept a host request only in DONE with nothing outstanding.
    if ((state == S_DONE) && rd_req && !rd_s1) begin
      rd_s1_n  = 1'b1;
      rd_idx_n = rd_addr;
    end

    case (state)
      S_IDLE: begin
        if (arm) begin
          state_n    = S_ARMED;
          wptr_n     = '0;
          wrapped_n  = 1'b0;
          post_cnt_n = '0;
        end
      end
      S_ARMED: begin
        if (trig || test_ending) state_n = S_TRIG;
      end
      S_TRIG: begin
        if (accept) post_cnt_n = post_cnt + 1'b1;
        if (test_ending || POST_ZERO ||
            (accept && (({1'b0, post_cnt} + 1'b1) == POST_TRIG_V)))
          state_n = S_DONE;
      end
      S_DONE: begin
        if (arm) begin
          state_n    = S_ARMED;
          wptr_n     = '0;
          wrapped_n  = 1'b0;
          post_cnt_n = '0;
          rd_s1_n    = 1'b0;
          rd_s2_n    = 1'b0;
          ack_n      = 1'b0;
          rdata_n    = rd_data;
        end
      end
      default: state_n = S_IDLE;
    endcase

    num_entries_n = wrapped_n ? DEPTH : {1'b0, wptr_n};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wptr        <= '0;
      wrapped     <= 1'b0;
      post_cnt    <= '0;
      tm_we       <= 1'b0;
      tm_waddr    <= '0;
      tm_wdata    <= '0;
      tm_raddr    <= '0;
      rd_s1       <= 1'b0;
      rd_s2       <= 1'b0;
      rd_idx      <= '0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      num_entries <= '0;
      trace_done  <= 1'b0;
    end else begin
      state       <= state_n;
      wptr        <= wptr_n;
      wrapped     <= wrapped_n;
      post_cnt    <= post_cnt_n;
      tm_we       <= we_n;
      tm_waddr    <= waddr_n;
      tm_wdata    <= wdata_n;
      tm_raddr    <= raddr_n;
      rd_s1       <= rd_s1_n;
      rd_s2       <= rd_s2_n;
      rd_idx      <= rd_idx_n;
      rd_ack      <= ack_n;
      rd_data     <= rdata_n;
      num_entries <= num_entries_n;
      trace_done  <= (state_n == S_DONE);
    end
  end

endmodule
